// File: rtl/output_serializer.sv
`default_nettype none
// ============================================================================
// Module   : output_serializer
// Brief    : Two-slot ping-pong row buffer that optionally Gray-decodes each
//            row on load and streams it out as BEATS narrow beats.
// Revision : 1.0  initial release
// ============================================================================
module output_serializer #(
    parameter int PIXEL_ARRAY_WIDTH = 8,
    parameter int OUTPUT_BUS_WIDTH  = 2,
    parameter int PIXEL_BITS        = 4,
    parameter int GRAY_DECODE       = 1,
    localparam int BEATS     = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH,
    localparam int BEAT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                                   CLK,
    input  logic                                   RESET,
    input  logic                                   FLUSH,
    input  logic                                   LOAD_VALID,
    output logic                                   LOAD_READY,
    input  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0] DATA_IN,
    output logic                                   OUT_VALID,
    input  logic                                   OUT_READY,
    output logic [OUTPUT_BUS_WIDTH*PIXEL_BITS-1:0] DATA_OUT,
    output logic                                   OUT_FIRST,
    output logic                                   OUT_LAST,
    output logic [BEAT_BITS-1:0]                   OUT_BEAT
);

    localparam int c_row_bits = PIXEL_ARRAY_WIDTH * PIXEL_BITS;
    localparam int c_bus_bits = OUTPUT_BUS_WIDTH * PIXEL_BITS;
    localparam logic [BEAT_BITS-1:0] c_last_beat = BEAT_BITS'(BEATS - 1);

    logic [c_row_bits-1:0] r_slot_0;
    logic [c_row_bits-1:0] r_slot_1;
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic [BEAT_BITS-1:0]  r_beat;

    logic [c_row_bits-1:0] w_decoded;
    logic [c_row_bits-1:0] w_row;
    logic [c_bus_bits-1:0] w_beat_data;
    logic                  w_load;
    logic                  w_xfer;
    logic                  w_pop;
    logic                  w_at_last;

    // Per-pixel input decode; binary bit i is the XOR of Gray bits MSB..i.
    generate
        for (genvar p = 0; p < PIXEL_ARRAY_WIDTH; p++) begin : g_pixel
            logic [PIXEL_BITS-1:0] w_gray;
            logic [PIXEL_BITS-1:0] w_bin;

            assign w_gray = DATA_IN[p*PIXEL_BITS +: PIXEL_BITS];

            if (GRAY_DECODE != 0) begin : g_gray
                for (genvar k = 0; k < PIXEL_BITS; k++) begin : g_bit
                    assign w_bin[k] = ^w_gray[PIXEL_BITS-1:k];
                end
            end else begin : g_raw
                assign w_bin = w_gray;
            end

            assign w_decoded[p*PIXEL_BITS +: PIXEL_BITS] = w_bin;
        end
    endgenerate

    assign LOAD_READY = (r_count != 2'd2) && !FLUSH && !RESET;
    assign OUT_VALID  = (r_count != 2'd0);
    assign w_at_last  = (r_beat == c_last_beat);
    assign w_load     = LOAD_VALID && LOAD_READY;
    assign w_xfer     = OUT_VALID && OUT_READY;
    assign w_pop      = w_xfer && w_at_last;

    assign w_row = r_rd_ptr ? r_slot_1 : r_slot_0;

    always_comb begin
        w_beat_data = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (r_beat == BEAT_BITS'(b)) begin
                w_beat_data = w_row[b*c_bus_bits +: c_bus_bits];
            end
        end
    end

    assign DATA_OUT  = OUT_VALID ? w_beat_data : '0;
    assign OUT_FIRST = OUT_VALID && (r_beat == '0);
    assign OUT_LAST  = OUT_VALID && w_at_last;
    assign OUT_BEAT  = r_beat;

    // Slot storage is deliberately left out of reset and flush.
    always_ff @(posedge CLK) begin
        if (w_load) begin
            if (r_wr_ptr) begin
                r_slot_1 <= w_decoded;
            end else begin
                r_slot_0 <= w_decoded;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET || FLUSH) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_beat   <= '0;
        end else begin
            if (w_load) begin
                r_wr_ptr <= ~r_wr_ptr;
            end

            if (w_xfer) begin
                if (w_at_last) begin
                    r_beat   <= '0;
                    r_rd_ptr <= ~r_rd_ptr;
                end else begin
                    r_beat <= r_beat + BEAT_BITS'(1);
                end
            end

            // A load coinciding with a final-beat pop leaves occupancy as is.
            unique case ({w_load, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/output_serializer.md
OUTPUT_SERIALIZER -- requirements
Module: output_serializer

Interface
REQ-001 Parameter PIXEL_ARRAY_WIDTH, default 8, SHALL be the pixels per row; it must be >=1.
REQ-002 Parameter OUTPUT_BUS_WIDTH, default 2, SHALL be the pixels per output beat; it must divide PIXEL_ARRAY_WIDTH.
REQ-003 Parameter PIXEL_BITS, default 4, SHALL be the bits per pixel.
REQ-004 Parameter GRAY_DECODE, default 1, SHALL select the input coding: 1 = Gray-to-binary decode on load, 0 = pass through.
REQ-005 Derived BEATS = PIXEL_ARRAY_WIDTH/OUTPUT_BUS_WIDTH; BEAT_BITS = max(1, clog2(BEATS)).
REQ-006 Ports SHALL be, in this order:
- CLK  in  1  single clock; all state changes on posedge.
- RESET  in  1  reset, synchronous, active-high.
- FLUSH  in  1  synchronous clear of buffered rows.
- LOAD_VALID  in  1  row offered on DATA_IN.
- LOAD_READY  out  1  row slot free.
- DATA_IN  in  PIXEL_ARRAY_WIDTH*PIXEL_BITS  row; pixel i at bits [i*PIXEL_BITS +: PIXEL_BITS].
- OUT_VALID  out  1  beat present on DATA_OUT.
- OUT_READY  in  1  sink accepts beat.
- DATA_OUT  out  OUTPUT_BUS_WIDTH*PIXEL_BITS  beat data.
- OUT_FIRST  out  1  current beat is beat 0 of a row.
- OUT_LAST  out  1  current beat is beat BEATS-1 of a row.
- OUT_BEAT  out  BEAT_BITS  index of current beat.

Function
REQ-007 The block SHALL hold a two-slot row buffer (ping-pong) with write pointer, read pointer and occupancy COUNT in 0..2.
REQ-008 LOAD_READY SHALL be combinational: (COUNT != 2) and not FLUSH and not RESET; a pop in the same cycle does not raise it.
REQ-009 A load SHALL occur at a posedge with LOAD_VALID & LOAD_READY: the row, decoded per GRAY_DECODE, is written to the write slot, and the write pointer toggles.
REQ-010 Gray decode per pixel SHALL be b[MSB] = g[MSB] and b[i] = b[i+1] XOR g[i], applied before storage.
REQ-011 OUT_VALID SHALL equal (COUNT != 0); with COUNT = 0, a row loaded at edge N is presented from cycle N+1 (one-cycle latency).
REQ-012 While OUT_VALID, DATA_OUT slice j SHALL carry pixel OUT_BEAT*OUTPUT_BUS_WIDTH + j of the read slot; DATA_OUT SHALL be 0 when OUT_VALID is low.
REQ-013 A beat handshake SHALL be OUT_VALID & OUT_READY at a posedge; OUT_BEAT increments on each handshake except the last.
REQ-014 On a handshake with OUT_BEAT = BEATS-1, OUT_BEAT SHALL wrap to 0, the read pointer toggles and COUNT decrements.
REQ-015 With OUT_VALID & !OUT_READY, DATA_OUT, OUT_BEAT, OUT_FIRST and OUT_LAST SHALL hold stable.
REQ-016 A simultaneous load and last-beat pop SHALL leave COUNT unchanged; a back-to-back row's beat 0 follows with no idle cycle.
REQ-017 OUT_FIRST SHALL be OUT_VALID & (OUT_BEAT = 0), and OUT_LAST SHALL be OUT_VALID & (OUT_BEAT = BEATS-1); with BEATS = 1 both are high together.
REQ-018 FLUSH at a posedge SHALL set COUNT, both pointers and OUT_BEAT to 0, discard any row mid-transfer, and ignore a coincident load.
REQ-019 Stored slot contents SHALL not be cleared by FLUSH; the contents are don't-care until reloaded.
REQ-020 Priority SHALL be RESET > FLUSH > load/pop.

Reset
REQ-021 RESET high at a posedge SHALL set COUNT = 0, pointers = 0 and OUT_BEAT = 0, giving OUT_VALID = 0, OUT_FIRST = 0, OUT_LAST = 0 and DATA_OUT = 0 from the next cycle.
REQ-022 While RESET is high, LOAD_READY SHALL be 0 and all inputs SHALL be ignored.
REQ-023 RESET asserted mid-row SHALL abandon the row; after release, LOAD_READY = 1 in the first cycle.
REQ-024 Slot storage need not be reset.

Verification (defaults, BEATS = 4, GRAY_DECODE = 1)
REQ-025 Single row: load pixels Gray {0,1,3,2,6,7,5,4} (binary 0..7) with OUT_READY=1 -> OUT_VALID high for 4 cycles starting the cycle after load; DATA_OUT = {1,0},{3,2},{5,4},{7,6} (slice1,slice0); OUT_FIRST on beat 0, OUT_LAST on beat 3.
REQ-026 Backpressure: OUT_READY low for 3 cycles during beat 1 -> DATA_OUT holds {3,2} and OUT_BEAT = 1 throughout; the row completes with no lost or duplicated beats.
REQ-027 Full buffer: load rows A and B with OUT_READY=0 -> COUNT=2 and LOAD_READY=0; offering row C is not accepted; on A's last-beat handshake LOAD_READY rises the following cycle.
REQ-028 Streaming: a new row is offered each time LOAD_READY is high, with OUT_READY=1 -> continuous OUT_VALID, exactly 4 beats per row, rows in load order, and OUT_LAST every 4th beat.
REQ-029 FLUSH during beat 2 with row B queued -> OUT_VALID=0 next cycle; a subsequently loaded row D starts at OUT_BEAT=0 with D's data.
REQ-030 Parameter sweep: GRAY_DECODE=0 passes raw data; the config PIXEL_ARRAY_WIDTH=4, OUTPUT_BUS_WIDTH=4 (BEATS=1) gives one beat per row with OUT_FIRST=OUT_LAST=1; RESET mid-row gives the values of REQ-021.
